// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller for a time-multiplexed FIR filter.
// Accepts one input sample at a time, pulses the delay-line shift, sweeps the
// tap address across all TAPS taps, drives the MAC enable/clear one cycle
// behind the address (the delay line registers its tap output), then holds
// the result valid until the consumer takes it.
// Optional feature: define FIR_CTRL_FLUSH_EN to add a 'flush' input that
// clears the delay line from IDLE via a one-cycle reset_shift pulse.
module fir_ctrl #(
  parameter int TAPS = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          probka_valid,
  output logic          probka_ready,
  output logic          nowa_shift,
  output logic          reset_shift,
  output logic [AW-1:0] adres,
  output logic [AW-1:0] wsp_adres,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          wynik_valid,
  input  logic          wynik_ready,
`ifdef FIR_CTRL_FLUSH_EN
  input  logic          flush,
`endif
  output logic          busy
);

  // FLUSH is only reachable when the flush feature is compiled in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    FLUSH = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] tap_cnt;
  logic          flush_req;
  logic          accept;

`ifdef FIR_CTRL_FLUSH_EN
  assign flush_req = flush && (state == IDLE);
`else
  assign flush_req = 1'b0;
`endif

  // A sample is taken only when the controller advertises ready.
  assign accept = probka_valid && probka_ready;

  // State register: asynchronous reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Tap counter: runs 0..TAPS-1 during SWEEP only, never wraps past the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
    end else if ((state == SWEEP) && (tap_cnt != LAST_TAP)) begin
      tap_cnt <= tap_cnt + ONE;
    end else begin
      tap_cnt <= '0;
    end
  end

  // Next-state logic: flush has priority over a new sample in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
        end else if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: state_next = SWEEP;
      SWEEP: begin
        if (tap_cnt == LAST_TAP) begin
          state_next = DRAIN;
        end
      end
      DRAIN: state_next = DONE;
      DONE: begin
        if (wynik_ready) begin
          state_next = IDLE;
        end
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: MAC strobes trail the address by one cycle to match tap data.
  always_comb begin
    probka_ready = (state == IDLE) && rst_n && !flush_req;
    nowa_shift   = (state == SHIFT);
`ifdef FIR_CTRL_FLUSH_EN
    reset_shift  = (state == FLUSH);
`else
    reset_shift  = 1'b0;
`endif
    adres        = (state == SWEEP) ? tap_cnt : '0;
    wsp_adres    = adres;
    mac_en       = ((state == SWEEP) && (tap_cnt != '0)) || (state == DRAIN);
    mac_clr      = (state == SWEEP) && (tap_cnt == ONE);
    wynik_valid  = (state == DONE);
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: self-checking bench for fir_ctrl.
// A TAPS=2 instance is checked against a hand-written cycle table; a TAPS=32
// instance is checked every cycle against a model that tracks only the number
// of cycles elapsed since the sample was accepted.
// With FIR_CTRL_FLUSH_EN defined, the flush path is exercised as well.
module tb_fir_ctrl;

  localparam int TAPS = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          probka_valid, wynik_ready, flush;
  logic          probka_ready, nowa_shift, reset_shift, mac_en, mac_clr;
  logic          wynik_valid, busy;
  logic [AW-1:0] adres, wsp_adres;

  logic          valid2, ready2;
  logic          pready2, nowa2, rs2, macen2, macclr2, wv2, busy2;
  logic [0:0]    adres2, wsp2;

  int checks = 0;
  int passes = 0;
  int ph = 0;

  always #5 clk = ~clk;

  fir_ctrl #(.TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .probka_valid(probka_valid), .probka_ready(probka_ready),
    .nowa_shift(nowa_shift), .reset_shift(reset_shift),
    .adres(adres), .wsp_adres(wsp_adres),
    .mac_en(mac_en), .mac_clr(mac_clr),
    .wynik_valid(wynik_valid), .wynik_ready(wynik_ready),
`ifdef FIR_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy)
  );

  fir_ctrl #(.TAPS(2), .AW(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .probka_valid(valid2), .probka_ready(pready2),
    .nowa_shift(nowa2), .reset_shift(rs2),
    .adres(adres2), .wsp_adres(wsp2),
    .mac_en(macen2), .mac_clr(macclr2),
    .wynik_valid(wv2), .wynik_ready(ready2),
`ifdef FIR_CTRL_FLUSH_EN
    .flush(1'b0),
`endif
    .busy(busy2)
  );

  typedef struct {
    logic valid;
    logic ready;
    logic e_pready;
    logic e_nowa;
    logic e_macen;
    logic e_macclr;
    logic e_wv;
    logic e_busy;
    int   e_adres;
  } vec_t;

  vec_t tbl [9];

  // Packs the big instance's outputs into one word for comparison.
  function automatic logic [31:0] observed();
    return {15'd0, probka_ready, nowa_shift, reset_shift, mac_en, mac_clr,
            wynik_valid, busy, adres, wsp_adres};
  endfunction

  // Expected outputs given p = cycles since acceptance (0 idle, -1 flushing).
  function automatic logic [31:0] modelOut(int p, logic f);
    logic [AW-1:0] a;
    a = (p >= 2 && p <= TAPS + 1) ? AW'(p - 2) : '0;
    return {15'd0, (p == 0) && !f, (p == 1), (p == -1),
            (p >= 3 && p <= TAPS + 2), (p == 3), (p == TAPS + 3),
            (p != 0), a, a};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s t=%0t actual=%h expected=%h ph=%0d",
                  name, $time, act, exp, ph);
  endtask

  // Drives one cycle on the big instance, checks it, then advances the model.
  task automatic applyStimulus(input logic v, input logic r, input logic f);
    probka_valid = v;
    wynik_ready  = r;
    flush        = f;
    @(negedge clk);
    checkOutput("cycle", observed(), modelOut(ph, f));
    @(posedge clk);
    if (ph == 0)             ph = f ? -1 : (v ? 1 : 0);
    else if (ph == -1)       ph = 0;
    else if (ph < TAPS + 3)  ph = ph + 1;
    else if (r)              ph = 0;
    #1;
  endtask

  initial begin
    int waited;
    int pulses;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    rst_n = 1'b0;
    probka_valid = 1'b0; wynik_ready = 1'b0; flush = 1'b0;
    valid2 = 1'b0; ready2 = 1'b0;

    // Reset state: everything low, including probka_ready.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", observed(), 32'd0);
    checkOutput("reset_state_t2",
                {23'd0, pready2, nowa2, rs2, macen2, macclr2, wv2, busy2, adres2, wsp2},
                32'd0);
    rst_n = 1'b1;
    #1;

    // TAPS=2 table: one full transaction with backpressure, then a second accept.
    for (int i = 0; i < 9; i++) begin
      valid2 = tbl[i].valid;
      ready2 = tbl[i].ready;
      @(negedge clk);
      checkOutput($sformatf("taps2_row%0d", i),
                  {23'd0, pready2, nowa2, rs2, macen2, macclr2, wv2, busy2, adres2, wsp2},
                  {23'd0, tbl[i].e_pready, tbl[i].e_nowa, 1'b0, tbl[i].e_macen,
                   tbl[i].e_macclr, tbl[i].e_wv, tbl[i].e_busy,
                   tbl[i].e_adres[0], tbl[i].e_adres[0]});
      @(posedge clk);
      #1;
    end
    valid2 = 1'b0;

    // Single sample with consumer ready.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && ph != 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Backpressure: result held 10 extra cycles while the next sample waits.
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, waited >= 10, 1'b0);
      if (ph == TAPS + 3) waited++;
      if (waited >= 10 && ph == 1) break;
    end
    for (int i = 0; i < 50 && ph != 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Back-to-back: one sample every TAPS+4 cycles.
    pulses = 0;
    for (int i = 0; i < 3 * (TAPS + 4); i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (nowa_shift) pulses++;
    end
    checkOutput("b2b_pulses", pulses, 3);
    for (int i = 0; i < 50 && ph != 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Asynchronous reset at adres = 13 aborts the sweep.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && ph != 15; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("adres_before_reset", 32'(adres), 32'd13);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", observed(), 32'd0);
    ph = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && ph != 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);

`ifdef FIR_CTRL_FLUSH_EN
    // Flush wins over a simultaneous sample; flush mid-sweep is ignored.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && ph != 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic f;
`ifdef FIR_CTRL_FLUSH_EN
      f = ($urandom_range(0, 15) == 0);
`else
      f = 1'b0;
`endif
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, f);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
